// File: rtl/id_ex_stage_if.sv
// Decode-to-execute handshake bundle: decode request/operand inputs and
// execute-side outputs of the ID/EX pipeline register.
interface id_ex_stage_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [DATA_WIDTH-1:0] inst_i;
  logic [DATA_WIDTH-1:0] rs1_rdata_i;
  logic [DATA_WIDTH-1:0] rs2_rdata_i;
  logic                  flush_i;
  logic                  ex_ready_i;
  logic                  out_valid_o;
  logic [DATA_WIDTH-1:0] inst_o;
  logic [DATA_WIDTH-1:0] op1_o;
  logic [DATA_WIDTH-1:0] op2_o;

  modport slave (
    input  in_valid_i, inst_i, rs1_rdata_i, rs2_rdata_i, flush_i, ex_ready_i,
    output in_ready_o, out_valid_o, inst_o, op1_o, op2_o
  );

  modport master (
    output in_valid_i, inst_i, rs1_rdata_i, rs2_rdata_i, flush_i, ex_ready_i,
    input  in_ready_o, out_valid_o, inst_o, op1_o, op2_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand generation and a one-entry skid buffer
// so in_ready_o is registered and never depends on ex_ready_i.
module id_ex_stage #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INST   = 32'h0000_0013
) (
  input logic            clk_i,
  input logic            rst_i,
  id_ex_stage_if.slave   bus
);

  localparam logic [6:0] OpImm = 7'b0010011;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] inst;
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;
  } entry_t;

  localparam entry_t EmptyEntry = '{inst: NOP_INST, op1: '0, op2: '0};

  entry_t main_q, main_d, skid_q, skid_d, new_entry;
  logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic   accept, consume;
  logic [6:0] opcode;
  logic [2:0] funct3;

  // Operand generation on the incoming instruction
  always_comb begin
    opcode        = bus.inst_i[6:0];
    funct3        = bus.inst_i[14:12];
    new_entry     = EmptyEntry;
    new_entry.inst = bus.inst_i;
    new_entry.op1  = bus.rs1_rdata_i;
    if (opcode == OpImm) begin
      if (funct3 == 3'b001 || funct3 == 3'b101) begin
        new_entry.op2 = {{(DATA_WIDTH-5){1'b0}}, bus.inst_i[24:20]};
      end else begin
        new_entry.op2 = {{(DATA_WIDTH-12){bus.inst_i[31]}}, bus.inst_i[31:20]};
      end
    end else begin
      new_entry.op2 = bus.rs2_rdata_i;
    end
  end

  assign bus.in_ready_o = ~skid_valid_q & ~rst_i;
  assign accept         = bus.in_valid_i & bus.in_ready_o & ~bus.flush_i;
  assign consume        = main_valid_q & bus.ex_ready_i;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (bus.flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // in_ready_o is low here, so nothing can be accepted this cycle
      if (consume) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q || consume) begin
      main_valid_d = accept;
      if (accept) main_d = new_entry;
    end else if (accept) begin
      skid_d       = new_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_q       <= EmptyEntry;
      skid_q       <= EmptyEntry;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign bus.out_valid_o = main_valid_q;
  assign bus.inst_o      = main_valid_q ? main_q.inst : NOP_INST;
  assign bus.op1_o       = main_valid_q ? main_q.op1 : '0;
  assign bus.op2_o       = main_valid_q ? main_q.op2 : '0;

endmodule
